seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for a DIGITS-wide common-anode 7-segment display.
//   Sequences one shared seg decoder across all digits: presents one nibble and DP at a time,
//   and drives the matching active-low anode. Inserts dead time between digits to stop ghosting.
//   Sits between the value source (counter/FSM) and the seg decoder plus board anodes.
// PARAMETERS
//   DIGITS       4      number of digits scanned; digit 0 = din[3:0] = an[0]
//   REFRESH_DIV  50000  clk cycles each digit is lit (ON slot), >=1
//   DEAD_CYC     100    clk cycles all anodes off between ON slots, >=1
// PORTS
//   clk         in   1          system clock, all state on rising edge
//   rst         in   1          synchronous, active-high reset
//   en          in   1          1 = scanning; 0 = display dark, scan frozen
//   load        in   1          1-cycle strobe: capture din/dp_in into pending regs
//   din         in   4*DIGITS   hex digits, nibble k -> digit k
//   dp_in       in   DIGITS     decimal point per digit, 1 = lit
//   nibble      out  4          value for the seg decoder (registered)
//   dp_out      out  1          DP of the current digit (registered)
//   an          out  DIGITS     anode enables, active-low, at most one bit low
//   frame_tick  out  1          1-cycle pulse when digit 0's ON slot begins
// BEHAVIOUR
// - Reset: state=DEAD, cnt=0, idx=0, pending=active=0 (value and DP), an=all 1, nibble=0,
//   dp_out=0, frame_tick=0. Reset dominates en/load and may hit any state, mid-slot included.
// - FSM, 2 states; cnt is $clog2(max(REFRESH_DIV,DEAD_CYC)) bits wide:
//     DEAD: an=all 1. When cnt==DEAD_CYC-1: cnt<=0, go ON. Else cnt++.
//     ON:   an[idx]=0, nibble=active[4*idx+:4], dp_out=active_dp[idx].
//           When cnt==REFRESH_DIV-1: cnt<=0, idx<=(idx==DIGITS-1)?0:idx+1, go DEAD. Else cnt++.
// - Outputs are registered and change on the same edge as the state/idx update. No
//   combinational path from inputs to outputs.
// - Update is frame-coherent. load writes pending. The DEAD->ON edge with idx==0 copies
//   pending->active and pulses frame_tick. No frame ever mixes old and new digits.
// - Same edge load and copy: active takes din/dp_in directly (bypass). pending also takes din.
// - en=0: next edge forces state=DEAD, cnt=0, an=all 1. idx and active are held; load still
//   accepted into pending. On en=1, a full DEAD period runs, then ON resumes at the held idx.
// - Frame length = DIGITS*(REFRESH_DIV+DEAD_CYC) cycles. idx wraps DIGITS-1 -> 0.
// CONFIGURATION
// - SEG_SCAN_LZB_EN defined: leading-zero blanking. In ON, digit idx>0 keeps an[idx]=1 if
//   active nibbles idx..DIGITS-1 are all 0 and active_dp[idx]=0. Digit 0 is never blanked.
//   Slot timing is unchanged.
// - Undefined: every digit is lit in its ON slot regardless of value.
// TESTING (DIGITS=4, REFRESH_DIV=4, DEAD_CYC=1)
// - Reset: rst=1 for 2 cycles with en=1 -> an=4'b1111, nibble=0, dp_out=0, frame_tick=0;
//   first an=4'b1110 appears 1 cycle after rst falls.
// - Scan: load 16'h1234, dp_in=4'b0100, en=1 -> an 1111x1, 1110x4 nib 4, 1111, 1101x4 nib 3,
//   1111, 1011x4 nib 2 dp_out=1, 1111, 0111x4 nib 1. Period 20; frame_tick once per 20.
// - Coherent load: load 16'hABCD while idx=2 ON -> digits 2,3 still show 2,1;
//   next frame shows D,C,B,A; frame_tick coincides with the first D.
// - en gating: en=0 mid-ON at idx=1 -> an=1111 next edge, held; en=1 -> 1 DEAD cycle,
//   then an=1101 for 4 cycles.
// - Reset mid-operation: rst pulse during idx=2 ON -> an=1111, active=0;
//   scan restarts at idx 0 showing 0.
// - LZB: din=16'h0040, dp_in=0 -> with SEG_SCAN_LZB_EN an[3],an[2] stay 1 in their slots,
//   digit1=4, digit0=0 lit. Without the macro all four digits are lit.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_DEAD | all anodes off, dead time between digit slots (or en=0)
// ST_ON   | anode idx driven low, nibble/dp_out show digit idx
module seg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [3:0]            nibble,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int MAXC = (REFRESH_DIV > DEAD_CYC) ? REFRESH_DIV : DEAD_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:0] ST_DEAD = 1'b0;
  localparam logic [0:0] ST_ON   = 1'b1;

  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] REFR_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [0:0]          state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] pend_val, act_val, act_val_nx;
  logic [DIGITS-1:0]   pend_dp, act_dp, act_dp_nx;
  logic [DIGITS-1:0]   an_on;
  logic                frame_start;
  logic                blank;

  // Active digits only change on the DEAD->ON edge that starts digit 0,
  // so a frame never mixes old and new values; a same-edge load bypasses pending.
  always_comb begin
    frame_start = en && (state == ST_DEAD) && (cnt == DEAD_LAST) && (idx == '0);
    act_val_nx  = act_val;
    act_dp_nx   = act_dp;
    if (frame_start) begin
      act_val_nx = load ? din   : pend_val;
      act_dp_nx  = load ? dp_in : pend_dp;
    end
    an_on = ~(DIGITS'(1) << idx);
  end

  always_comb begin
    blank = 1'b0;
`ifdef SEG_SCAN_LZB_EN
    begin
      logic upper_nz;
      upper_nz = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
        if ((IW'(k) >= idx) && (act_val_nx[4*k +: 4] != 4'h0))
          upper_nz = 1'b1;
      end
      blank = (idx != '0) && !upper_nz && !act_dp_nx[idx];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_DEAD;
      cnt        <= '0;
      idx        <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      an         <= '1;
      nibble     <= 4'h0;
      dp_out     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (load) begin
        pend_val <= din;
        pend_dp  <= dp_in;
      end
      if (!en) begin
        state <= ST_DEAD;
        cnt   <= '0;
        an    <= '1;
      end else if (state == ST_DEAD) begin
        if (cnt == DEAD_LAST) begin
          cnt        <= '0;
          state      <= ST_ON;
          act_val    <= act_val_nx;
          act_dp     <= act_dp_nx;
          an         <= blank ? '1 : an_on;
          nibble     <= act_val_nx[{idx, 2'b00} +: 4];
          dp_out     <= act_dp_nx[idx];
          frame_tick <= (idx == '0);
        end else begin
          cnt <= cnt + 1'b1;
          an  <= '1;
        end
      end else begin
        if (cnt == REFR_LAST) begin
          cnt   <= '0;
          idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          state <= ST_DEAD;
          an    <= '1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (DIGITS=4, REFRESH_DIV=4, DEAD_CYC=1).
// Each expected anode run (value, nibble, dp, frame_tick, length) is queued up front.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic [3:0]  nibble;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_tick;

  seg_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(4), .DEAD_CYC(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .dp_in(dp_in),
    .nibble(nibble), .dp_out(dp_out), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [3:0] nib;
    logic       dp;
    logic       ft;
    int         len;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic exp(input logic [3:0] a, input logic [3:0] n, input logic d,
                     input logic f, input int l);
    exp_t e;
    e.an = a; e.nib = n; e.dp = d; e.ft = f; e.len = l;
    q.push_back(e);
  endtask

  // Monitor: a new anode value marks the start of a run and pops one expectation.
  bit         mon_en = 1'b0;
  bit         mon_first = 1'b1;
  exp_t       cur;
  int         run_len = 0;
  int         item_no = 0;
  int         ft_seen = 0;
  logic [3:0] prev_an = 4'h0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_tick === 1'b1) ft_seen++;
      if (mon_first || an !== prev_an) begin
        if (!mon_first && cur.len != 0)
          check($sformatf("run_len item %0d", item_no), run_len, cur.len);
        mon_first = 1'b0;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_run: got an=%b, want no further change", an);
          cur.len = 0;
        end else begin
          cur = q.pop_front();
          item_no++;
          check($sformatf("an item %0d", item_no), an, cur.an);
          if (cur.an != 4'hF) begin
            check($sformatf("nibble item %0d", item_no), nibble, cur.nib);
            check($sformatf("dp_out item %0d", item_no), dp_out, cur.dp);
          end
          check($sformatf("frame_tick item %0d", item_no), frame_tick, cur.ft);
        end
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_an = an;
    end
  end

  int ecount;
  task automatic go_to(input int k);
    while (ecount < k) begin
      @(posedge clk);
      #1;
      ecount++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; din = 16'h0; dp_in = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset an", an, 4'hF);
    check("reset nibble", nibble, 4'h0);
    check("reset dp_out", dp_out, 1'b0);
    check("reset frame_tick", frame_tick, 1'b0);

    // Frame 1: 1234, dp on digit 2 (loaded on the first copy edge -> bypass)
    exp(4'hE, 4'h4, 0, 1, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'hD, 4'h3, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'hB, 4'h2, 1, 0, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'h7, 4'h1, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
    // Frame 2: ABCD, dp on digit 0
    exp(4'hE, 4'hD, 1, 1, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'hD, 4'hC, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'hB, 4'hB, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'h7, 4'hA, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
    // Frame 3 with en=0 for 5 edges during digit 1
    exp(4'hE, 4'hD, 1, 1, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'hD, 4'hC, 0, 0, 1); exp(4'hF, 0, 0, 0, 5);
    exp(4'hD, 4'hC, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'hB, 4'hB, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'h7, 4'hA, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
    // Frame 4 cut by reset during digit 2
    exp(4'hE, 4'hD, 1, 1, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'hD, 4'hC, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'hB, 4'hB, 0, 0, 1); exp(4'hF, 0, 0, 0, 1);
    // Frame after reset: all zeros
    exp(4'hE, 4'h0, 0, 1, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'hD, 4'h0, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'hB, 4'h0, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'h7, 4'h0, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
    // Frame with 0040
    exp(4'hE, 4'h0, 0, 1, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'hD, 4'h4, 0, 0, 4);
`ifdef SEG_SCAN_LZB_EN
    exp(4'hF, 0, 0, 0, 11);
`else
    exp(4'hF, 0, 0, 0, 1);
    exp(4'hB, 4'h0, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
    exp(4'h7, 4'h0, 0, 0, 4); exp(4'hF, 0, 0, 0, 1);
`endif
    exp(4'hE, 4'h0, 0, 1, 4); exp(4'hF, 0, 0, 0, 0);

    #1;
    rst = 1'b0; load = 1'b1; din = 16'h1234; dp_in = 4'b0100;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    ecount = 0;
    load = 1'b0;

    go_to(10); load = 1'b1; din = 16'hABCD; dp_in = 4'b0001;
    go_to(11); load = 1'b0;
    go_to(45); en = 1'b0;
    go_to(50); en = 1'b1;
    go_to(76); rst = 1'b1;
    go_to(77); rst = 1'b0;
    go_to(84); load = 1'b1; din = 16'h0040; dp_in = 4'b0000;
    go_to(85); load = 1'b0;
    go_to(122);
    @(negedge clk);
    #1;
    mon_en = 1'b0;

    check("queue_left", q.size(), 0);
    check("frame_tick_count", ft_seen, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
